digit_scan_controller: RTL and testbench
========================================

Name: digit_scan_controller

Overview:
- Sequential scan generator that sits directly upstream of the 2-to-4 line decoder.
- Steps a 2-bit digit index through the enabled digits of a 4-digit multiplexed display, holding each digit for a programmable dwell time.
- Inserts a programmable blanking gap between digits to suppress ghosting.
- Drives sel_a/sel_b into the decoder's a/b inputs, plus a valid qualifier the consumer ANDs with the decoder outputs.

Parameters:
- DWELL, 100000, clock cycles each digit is shown (sel_valid=1); legal range 1..2^20-1.
- BLANK, 1000, clock cycles of blanking after each digit (sel_valid=0); 0 = no blanking.
- CNT_W, 20, width of the shared dwell/blank down-counter; must hold max(DWELL, BLANK).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; 0 forces IDLE.
- digit_mask  input  4  bit i=1 means digit i participates in the scan.
- sel_a  output  1  index MSB (idx[1]); feeds decoder input a.
- sel_b  output  1  index LSB (idx[0]); feeds decoder input b.
- sel_valid  output  1  1 while the selected digit must be lit.
- scan_tick  output  1  one-cycle pulse on the first cycle of every SHOW.
- frame_tick  output  1  one-cycle pulse when the index wraps to a lower-or-equal enabled digit.

Behaviour:
- Reset (async assert, sync release effect):
  - state=IDLE, idx=0, counter=0.
  - sel_a=sel_b=0, sel_valid=0, scan_tick=0, frame_tick=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Mapping: idx 0..3 -> decoder d0..d3 (idx = {sel_a, sel_b}).
- next_enabled(i, m): first set bit of m searching i+1, i+2, i+3, i (mod 4). Returns i when i is the only set bit.
- IDLE:
  - sel_valid=0.
  - If en=1 and mask!=0 at an edge: go to SHOW with idx = lowest set bit of mask, counter=DWELL-1, scan_tick=1, frame_tick=0.
- SHOW:
  - sel_valid=1; counter decrements each cycle.
  - At counter==0: if BLANK>0, go to BLANK with counter=BLANK-1.
  - If BLANK==0, advance directly (same rules as below).
- BLANK:
  - sel_valid=0, idx unchanged; counter decrements.
  - At counter==0, advance:
    - idx_n = next_enabled(idx, digit_mask); go to SHOW with counter=DWELL-1, scan_tick=1.
    - frame_tick=1 iff idx_n <= idx.
- Timing: each digit occupies exactly DWELL+BLANK cycles. scan_tick period = DWELL+BLANK.
- digit_mask is sampled only at advance time. A change mid-SHOW/BLANK does not shorten the current digit.
- Abort: en=0 or digit_mask==0 in SHOW/BLANK -> IDLE on the next edge.
  - sel_valid drops that edge; idx is held, not cleared.
  - Re-entry restarts at the lowest enabled digit.
- Simultaneous abort and advance: abort wins; no tick is emitted.
- Single enabled digit: digit stays constant. With BLANK>0 it still blanks every DWELL cycles, and frame_tick fires on every advance.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Package digit_scan_pkg holds:
  - state encoding localparams ST_IDLE=2'b00, ST_SHOW=2'b01, ST_BLANK=2'b10;
  - function first_set(mask) for entry;
  - function next_enabled(idx, mask).
- One combinational sub-module is natural: scan_next_index (inputs idx[1:0], mask[3:0]; output nxt[1:0], wrap). The main module keeps the FSM and counter.

Test Plan (DWELL=4, BLANK=2 unless noted):
- Reset then en=1, mask=4'b1111:
  - first SHOW: idx=0, sel_valid=1 for 4 cycles, then 0 for 2 cycles;
  - idx sequence 0,1,2,3,0;
  - scan_tick every 6 cycles; frame_tick only on the 3->0 advance.
- mask=4'b1010: idx sequence 1,3,1,3; frame_tick on each 3->1 advance; digits 0 and 2 never selected.
- mask=4'b0100: idx stays 2; sel_valid pattern 1111_00 repeating; scan_tick and frame_tick together every 6 cycles.
- BLANK=0, mask=4'b1111: sel_valid stays 1 continuously after entry; idx advances every 4 cycles.
- en dropped on cycle 2 of a SHOW of idx=1:
  - next edge: sel_valid=0, state IDLE, idx held at 1;
  - en re-raised: idx=0 with scan_tick=1.
- rst asserted asynchronously mid-BLANK (between clock edges): all outputs 0 immediately, before the next edge. After release with en=1, the scan restarts at the lowest enabled digit.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared definitions for the digit scan controller: state encoding and
// digit-index search helpers used on entry and on every advance.
package digit_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHOW  = 2'b01,
        ST_BLANK = 2'b10
    } scan_state_e;

    // Lowest set bit of the mask; 0 when the mask is empty.
    function automatic logic [1:0] first_set(input logic [3:0] mask);
        logic [1:0] res;
        res = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                res = 2'(i);
            end
        end
        return res;
    endfunction

    // First set bit searching idx+1, idx+2, idx+3 (mod 4); falls back to idx itself.
    function automatic logic [1:0] next_enabled(input logic [1:0] idx, input logic [3:0] mask);
        logic [1:0] res;
        logic [1:0] cand;
        res = idx;
        for (int k = 3; k >= 1; k--) begin
            cand = idx + 2'(k);
            if (mask[cand]) begin
                res = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/digit_scan_controller_next_index.sv
// Combinational successor lookup: next enabled digit after idx and whether
// moving to it wraps the frame.
module scan_next_index
    import digit_scan_pkg::*;
(
    input  logic [1:0] idx,
    input  logic [3:0] mask,
    output logic [1:0] nxt,
    output logic       wrap
);

    // Successor digit and frame-wrap flag
    always_comb begin
        nxt  = next_enabled(idx, mask);
        wrap = (nxt <= idx);
    end

endmodule

// File: rtl/digit_scan_controller.sv
// Scan generator for a 4-digit multiplexed display: holds each enabled digit
// for DWELL cycles followed by BLANK cycles of blanking, with registered outputs.
module digit_scan_controller
    import digit_scan_pkg::*;
#(
    parameter int DWELL = 100000,
    parameter int BLANK = 1000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic       sel_a,
    output logic       sel_b,
    output logic       sel_valid,
    output logic       scan_tick,
    output logic       frame_tick
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

    scan_state_e      state_r, state_s;
    logic [1:0]       idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             valid_r, valid_s;
    logic             scan_r, scan_s;
    logic             frame_r, frame_s;
    logic             abort_s;
    logic [1:0]       nxt_s;
    logic             wrap_s;

    scan_next_index u_next (
        .idx  (idx_r),
        .mask (digit_mask),
        .nxt  (nxt_s),
        .wrap (wrap_s)
    );

    // Next-state, counter and registered-output logic
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        valid_s = 1'b0;
        scan_s  = 1'b0;
        frame_s = 1'b0;
        abort_s = (!en) || (digit_mask == 4'b0000);
        case (state_r)
            ST_IDLE: begin
                if (!abort_s) begin
                    state_s = ST_SHOW;
                    idx_s   = first_set(digit_mask);
                    cnt_s   = DWELL_LOAD;
                    valid_s = 1'b1;
                    scan_s  = 1'b1;
                end else begin
                    cnt_s = '0;
                end
            end
            ST_SHOW: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (cnt_r != '0) begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    valid_s = 1'b1;
                end else if (BLANK > 0) begin
                    state_s = ST_BLANK;
                    cnt_s   = BLANK_LOAD;
                end else begin
                    // No blanking: advance straight into the next digit
                    idx_s   = nxt_s;
                    cnt_s   = DWELL_LOAD;
                    valid_s = 1'b1;
                    scan_s  = 1'b1;
                    frame_s = wrap_s;
                end
            end
            ST_BLANK: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (cnt_r != '0) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    state_s = ST_SHOW;
                    idx_s   = nxt_s;
                    cnt_s   = DWELL_LOAD;
                    valid_s = 1'b1;
                    scan_s  = 1'b1;
                    frame_s = wrap_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 2'b00;
                cnt_s   = '0;
            end
        endcase
    end

    // State, index, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'b00;
            cnt_r   <= '0;
            valid_r <= 1'b0;
            scan_r  <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            valid_r <= valid_s;
            scan_r  <= scan_s;
            frame_r <= frame_s;
        end
    end

    assign sel_a      = idx_r[1];
    assign sel_b      = idx_r[0];
    assign sel_valid  = valid_r;
    assign scan_tick  = scan_r;
    assign frame_tick = frame_r;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Randomised and directed bench for digit_scan_controller against a
// digit-period model; dut0 uses DWELL=4/BLANK=2, dut1 uses DWELL=4/BLANK=0.
module tb_digit_scan_controller;

    localparam int DW = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] mask;

    logic sel_a0, sel_b0, sel_valid0, scan_tick0, frame_tick0;
    logic sel_a1, sel_b1, sel_valid1, scan_tick1, frame_tick1;

    int n_vec = 0;
    int n_err = 0;

    digit_scan_controller #(.DWELL(DW), .BLANK(2), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
        .sel_a(sel_a0), .sel_b(sel_b0), .sel_valid(sel_valid0),
        .scan_tick(scan_tick0), .frame_tick(frame_tick0)
    );

    digit_scan_controller #(.DWELL(DW), .BLANK(0), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
        .sel_a(sel_a1), .sel_b(sel_b1), .sel_valid(sel_valid1),
        .scan_tick(scan_tick1), .frame_tick(frame_tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a digit lasts 'period' cycles; ph counts cycles since its first SHOW cycle
    typedef struct packed {
        logic        act;
        logic [1:0]  idx;
        int unsigned ph;
        logic        scan;
        logic        frame;
    } mstate_t;

    mstate_t m0, m1;

    function automatic mstate_t model_next(input mstate_t s, input int unsigned period,
                                           input logic e, input logic [3:0] m);
        mstate_t n;
        int      pick;
        n       = s;
        n.scan  = 1'b0;
        n.frame = 1'b0;
        if (!s.act) begin
            if (e && m != 4'b0000) begin
                pick = 0;
                for (int k = 3; k >= 0; k--) if (m[k]) pick = k;
                n.act  = 1'b1;
                n.idx  = 2'(pick);
                n.ph   = 0;
                n.scan = 1'b1;
            end
        end else if (!e || m == 4'b0000) begin
            n.act = 1'b0;
        end else if (s.ph + 1 == period) begin
            pick = int'(s.idx);
            for (int k = 4; k >= 1; k--) if (m[(int'(s.idx) + k) % 4]) pick = (int'(s.idx) + k) % 4;
            n.idx   = 2'(pick);
            n.ph    = 0;
            n.scan  = 1'b1;
            n.frame = (pick <= int'(s.idx));
        end else begin
            n.ph = s.ph + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= model_next(m0, 6, en, mask);
            m1 <= model_next(m1, 4, en, mask);
        end
    end

    logic [4:0] obs0, obs1, exp0, exp1;
    assign obs0 = {sel_a0, sel_b0, sel_valid0, scan_tick0, frame_tick0};
    assign obs1 = {sel_a1, sel_b1, sel_valid1, scan_tick1, frame_tick1};
    assign exp0 = {m0.idx, m0.act && (m0.ph < DW), m0.scan, m0.frame};
    assign exp1 = {m1.idx, m1.act && (m1.ph < DW), m1.scan, m1.frame};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_idle();
        en = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mask = 4'b0000;
        step();
        n_vec++;
        if (obs0 !== 5'b00000) begin n_err++; $display("FAIL reset_dut0 got %b want 00000", obs0); end
        n_vec++;
        if (obs1 !== 5'b00000) begin n_err++; $display("FAIL reset_dut1 got %b want 00000", obs1); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_mask();
        logic [1:0] seq[$];
        int frames = 0;
        int gaps1 = 0;
        go_idle();
        mask = 4'b1111; en = 1'b1;
        for (int c = 0; c < 31; c++) begin
            step();
            n_vec++;
            if (obs0 !== exp0) begin n_err++; $display("FAIL full_dut0 c%0d got %b want %b", c, obs0, exp0); end
            n_vec++;
            if (obs1 !== exp1) begin n_err++; $display("FAIL full_dut1 c%0d got %b want %b", c, obs1, exp1); end
            if (scan_tick0) seq.push_back({sel_a0, sel_b0});
            if (frame_tick0) frames++;
            if (!sel_valid1) gaps1++;
        end
        n_vec++;
        if (seq.size() != 6 || seq[0] != 2'd0 || seq[1] != 2'd1 || seq[2] != 2'd2 || seq[3] != 2'd3 || seq[4] != 2'd0)
            begin n_err++; $display("FAIL full_seq got %0d ticks first %p want 6 ticks 0,1,2,3,0", seq.size(), seq); end
        n_vec++;
        if (frames != 1) begin n_err++; $display("FAIL full_frames got %0d want 1", frames); end
        n_vec++;
        if (gaps1 != 0) begin n_err++; $display("FAIL noblank_valid got %0d gaps want 0", gaps1); end
    endtask

    task automatic test_mask_1010();
        logic [1:0] seq[$];
        int frames = 0;
        int bad = 0;
        go_idle();
        mask = 4'b1010; en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            step();
            n_vec++;
            if (obs0 !== exp0) begin n_err++; $display("FAIL m1010_dut0 c%0d got %b want %b", c, obs0, exp0); end
            if (scan_tick0) seq.push_back({sel_a0, sel_b0});
            if (frame_tick0) frames++;
            if (sel_valid0 && !sel_b0) bad++;
        end
        n_vec++;
        if (seq.size() != 4 || seq[0] != 2'd1 || seq[1] != 2'd3 || seq[2] != 2'd1 || seq[3] != 2'd3)
            begin n_err++; $display("FAIL m1010_seq got %p want 1,3,1,3", seq); end
        n_vec++;
        if (frames != 1) begin n_err++; $display("FAIL m1010_frames got %0d want 1", frames); end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL m1010_even got %0d want 0", bad); end
    endtask

    task automatic test_single_digit();
        int ticks = 0;
        int frames = 0;
        int bad = 0;
        go_idle();
        mask = 4'b0100; en = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            n_vec++;
            if (obs0 !== exp0) begin n_err++; $display("FAIL single_dut0 c%0d got %b want %b", c, obs0, exp0); end
            if (sel_valid0 !== ((c % 6) < 4)) bad++;
            if ({sel_a0, sel_b0} != 2'd2) bad++;
            if (scan_tick0) ticks++;
            if (frame_tick0 && scan_tick0) frames++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL single_pattern got %0d bad cycles want 0", bad); end
        n_vec++;
        if (ticks != 3 || frames != 2) begin n_err++; $display("FAIL single_ticks got %0d/%0d want 3/2", ticks, frames); end
    endtask

    task automatic test_abort();
        int budget = 0;
        go_idle();
        mask = 4'b1111; en = 1'b1;
        step();
        while (!(scan_tick0 && {sel_a0, sel_b0} == 2'd1) && budget < 20) begin
            step();
            budget++;
        end
        n_vec++;
        if (budget >= 20) begin n_err++; $display("FAIL abort_wait got timeout want idx1 tick"); end
        step();
        en = 1'b0;
        step();
        n_vec++;
        if ({sel_valid0, sel_a0, sel_b0, scan_tick0} !== 4'b0010)
            begin n_err++; $display("FAIL abort_drop got %b want 0010", {sel_valid0, sel_a0, sel_b0, scan_tick0}); end
        n_vec++;
        if (obs0 !== exp0) begin n_err++; $display("FAIL abort_model got %b want %b", obs0, exp0); end
        en = 1'b1;
        step();
        n_vec++;
        if ({sel_a0, sel_b0, sel_valid0, scan_tick0} !== 4'b0011)
            begin n_err++; $display("FAIL abort_reentry got %b want 0011", {sel_a0, sel_b0, sel_valid0, scan_tick0}); end
    endtask

    task automatic test_random();
        go_idle();
        mask = 4'b1111;
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
            step();
            n_vec++;
            if (obs0 !== exp0) begin n_err++; $display("FAIL rand_dut0 c%0d got %b want %b", c, obs0, exp0); end
            n_vec++;
            if (obs1 !== exp1) begin n_err++; $display("FAIL rand_dut1 c%0d got %b want %b", c, obs1, exp1); end
        end
    endtask

    task automatic test_async_reset();
        int budget = 0;
        go_idle();
        mask = 4'b0110; en = 1'b1;
        step();
        while (!(m0.act && m0.ph >= DW) && budget < 20) begin
            step();
            budget++;
        end
        n_vec++;
        if (budget >= 20 || sel_valid0 !== 1'b0)
            begin n_err++; $display("FAIL arst_blank got valid %b budget %0d want blanking", sel_valid0, budget); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (obs0 !== 5'b00000) begin n_err++; $display("FAIL arst_dut0 got %b want 00000", obs0); end
        n_vec++;
        if (obs1 !== 5'b00000) begin n_err++; $display("FAIL arst_dut1 got %b want 00000", obs1); end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_vec++;
        if ({sel_a0, sel_b0, sel_valid0, scan_tick0} !== 4'b0111)
            begin n_err++; $display("FAIL arst_restart got %b want 0111", {sel_a0, sel_b0, sel_valid0, scan_tick0}); end
        n_vec++;
        if (obs1 !== exp1) begin n_err++; $display("FAIL arst_dut1_model got %b want %b", obs1, exp1); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mask = 4'b0000;
        test_reset();
        test_full_mask();
        test_mask_1010();
        test_single_digit();
        test_abort();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
